// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetches into IR, walks FETCH/DECODE/EXEC/MEM/WB,
// owns the PC with its branch/jump arithmetic, and decodes datapath strobes from state and IR.
module cpu_sequencer #(
    parameter int I_W  = 32,
    parameter int PC_W = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [I_W-1:0]  INSTR,
    input  logic            IMEM_BUSY,
    input  logic            DMEM_BUSY,
    input  logic            ZERO,
    output logic [PC_W-1:0] PC,
    output logic [I_W-1:0]  IR,
    output logic            IMEM_READ,
    output logic [2:0]      ALUOP,
    output logic            COMP_SEL,
    output logic            IMM_SEL,
    output logic            REG_WE,
    output logic            WB_SEL,
    output logic            DMEM_READ,
    output logic            DMEM_WRITE,
    output logic            ILLEGAL
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_LWD   = 8'd8;
    localparam logic [7:0] OP_LWI   = 8'd9;
    localparam logic [7:0] OP_SWD   = 8'd10;
    localparam logic [7:0] OP_SWI   = 8'd11;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    state_t          state, state_next;
    logic [PC_W-1:0] pc_next, pc_plus4, pc_target;
    logic [I_W-1:0]  ir_next;
    logic [7:0]      opcode;
    logic            is_illegal, is_load;

    assign opcode     = IR[31:24];
    assign is_illegal = (opcode > OP_SWI);
    assign is_load    = (opcode == OP_LWD) || (opcode == OP_LWI);
    assign pc_plus4   = PC + PC_W'(4);
    // Branch offset is a signed word count, so scale by 4 after sign extension.
    assign pc_target  = pc_plus4 + {{(PC_W-10){IR[23]}}, IR[23:16], 2'b00};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= FETCH;
            PC    <= '0;
            IR    <= '0;
        end else begin
            state <= state_next;
            PC    <= pc_next;
            IR    <= ir_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = PC;
        ir_next    = IR;
        case (state)
            FETCH: begin
                if (!IMEM_BUSY) begin
                    ir_next    = INSTR;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_illegal) begin
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (opcode == OP_J) begin
                    pc_next    = pc_target;
                    state_next = FETCH;
                end else if (opcode == OP_BEQ) begin
                    pc_next    = ZERO ? pc_target : pc_plus4;
                    state_next = FETCH;
                end else if (opcode >= OP_LWD) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                if (!DMEM_BUSY) begin
                    if (is_load) begin
                        state_next = WB;
                    end else begin
                        pc_next    = pc_plus4;
                        state_next = FETCH;
                    end
                end
            end
            WB: begin
                pc_next    = pc_plus4;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // ALU controls persist from EXEC through MEM/WB so the datapath result stays stable.
    always_comb begin
        logic [2:0] alu_op;
        logic       comp, imm;
        alu_op = ALU_FWD;
        comp   = 1'b0;
        imm    = 1'b0;
        if (state == EXEC || state == MEM || state == WB) begin
            case (opcode)
                OP_LOADI, OP_LWI, OP_SWI: imm = 1'b1;
                OP_ADD:                   alu_op = ALU_ADD;
                OP_SUB, OP_BEQ: begin
                    alu_op = ALU_ADD;
                    comp   = 1'b1;
                end
                OP_AND:                   alu_op = ALU_AND;
                OP_OR:                    alu_op = ALU_OR;
                default:                  alu_op = ALU_FWD;
            endcase
        end
        ALUOP      = RESET ? ALU_FWD : alu_op;
        COMP_SEL   = !RESET && comp;
        IMM_SEL    = !RESET && imm;
        IMEM_READ  = !RESET && (state == FETCH);
        ILLEGAL    = !RESET && (state == DECODE) && is_illegal;
        REG_WE     = !RESET && (state == WB);
        WB_SEL     = !RESET && (state == WB) && is_load;
        DMEM_READ  = !RESET && (state == MEM) && is_load;
        DMEM_WRITE = !RESET && (state == MEM) && !is_load;
    end

endmodule
